// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM port between requesters A and B.
// Issues one command at a time and steers read data back to the granted requester.
module ram_port_arbiter #(
  parameter int AW     = 4,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          ram_en,
  output logic          ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          busy
);
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_RD} state_t;
  state_t r_state, w_nxt;

  logic [CW-1:0] r_cnt;
  logic          r_last_b, r_own_b;
  logic          r_en, r_wen;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_din;
  logic          r_a_gnt, r_b_gnt, r_a_rv, r_b_rv;
  logic [DW-1:0] r_a_rdata, r_b_rdata;

  logic          w_any, w_sel_b, w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  // On a tie the requester that did not win last time goes first.
  assign w_any   = a_req | b_req;
  assign w_sel_b = b_req & (~a_req | ~r_last_b);
  assign w_we    = w_sel_b ? b_we    : a_we;
  assign w_addr  = w_sel_b ? b_addr  : a_addr;
  assign w_wdata = w_sel_b ? b_wdata : a_wdata;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_nxt = S_CMD;
      S_CMD:   w_nxt = r_wen ? S_IDLE : S_RD;
      S_RD:    if (r_cnt == '0) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_last_b  <= 1'b1;
      r_own_b   <= 1'b0;
      r_en      <= 1'b0;
      r_wen     <= 1'b0;
      r_addr    <= '0;
      r_din     <= '0;
      r_a_gnt   <= 1'b0;
      r_b_gnt   <= 1'b0;
      r_a_rv    <= 1'b0;
      r_b_rv    <= 1'b0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      r_state <= w_nxt;
      r_en    <= 1'b0;
      r_wen   <= 1'b0;
      r_a_gnt <= 1'b0;
      r_b_gnt <= 1'b0;
      r_a_rv  <= 1'b0;
      r_b_rv  <= 1'b0;
      case (r_state)
        S_IDLE: if (w_any) begin
          r_en     <= 1'b1;
          r_wen    <= w_we;
          r_addr   <= w_addr;
          r_din    <= w_we ? w_wdata : '0;
          r_a_gnt  <= ~w_sel_b;
          r_b_gnt  <= w_sel_b;
          r_last_b <= w_sel_b;
          r_own_b  <= w_sel_b;
        end
        S_CMD: r_cnt <= CW'(RD_LAT - 1);
        S_RD: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            if (r_own_b) begin
              r_b_rdata <= ram_dout;
              r_b_rv    <= 1'b1;
            end else begin
              r_a_rdata <= ram_dout;
              r_a_rv    <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign a_gnt    = r_a_gnt;
  assign b_gnt    = r_b_gnt;
  assign a_rvalid = r_a_rv;
  assign b_rvalid = r_b_rv;
  assign a_rdata  = r_a_rdata;
  assign b_rdata  = r_b_rdata;
  assign ram_en   = r_en;
  assign ram_wen  = r_wen;
  assign ram_addr = r_addr;
  assign ram_din  = r_din;
  assign busy     = (r_state != S_IDLE);
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: one instance at RD_LAT=1 and one at RD_LAT=3,
// each attached to a small behavioural RAM with matching read latency.
module tb_ram_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // instance 0, RD_LAT = 1
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [3:0] a_addr = 0, b_addr = 0;
  logic [7:0] a_wdata = 0, b_wdata = 0;
  logic a_gnt, a_rvalid, b_gnt, b_rvalid, ram_en, ram_wen, busy;
  logic [7:0] a_rdata, b_rdata, ram_din, ram_dout;
  logic [3:0] ram_addr;

  // instance 1, RD_LAT = 3 (only A used)
  logic c_req = 0, c_we = 0, d_tie = 0;
  logic [3:0] c_addr = 0, d_addr = 0;
  logic [7:0] c_wdata = 0, d_wdata = 0;
  logic c_gnt, c_rvalid, d_gnt, d_rvalid, r1_en, r1_wen, busy1;
  logic [7:0] c_rdata, d_rdata, r1_din, r1_dout;
  logic [3:0] r1_addr;

  ram_port_arbiter #(.AW(4), .DW(8), .RD_LAT(1)) dut0 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .busy(busy));

  ram_port_arbiter #(.AW(4), .DW(8), .RD_LAT(3)) dut1 (
    .clk(clk), .rst(rst),
    .a_req(c_req), .a_we(c_we), .a_addr(c_addr), .a_wdata(c_wdata),
    .a_gnt(c_gnt), .a_rvalid(c_rvalid), .a_rdata(c_rdata),
    .b_req(d_tie), .b_we(d_tie), .b_addr(d_addr), .b_wdata(d_wdata),
    .b_gnt(d_gnt), .b_rvalid(d_rvalid), .b_rdata(d_rdata),
    .ram_en(r1_en), .ram_wen(r1_wen), .ram_addr(r1_addr), .ram_din(r1_din),
    .ram_dout(r1_dout), .busy(busy1));

  // behavioural RAMs: dout valid RD_LAT edges after the enabled edge
  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];
  logic [7:0] rd0;
  logic [7:0] rd1 [3];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wen) mem0[ram_addr] <= ram_din;
      rd0 <= mem0[ram_addr];
    end
    if (r1_en) begin
      if (r1_wen) mem1[r1_addr] <= r1_din;
      rd1[0] <= mem1[r1_addr];
    end
    rd1[1] <= rd1[0];
    rd1[2] <= rd1[1];
  end
  assign ram_dout = rd0;
  assign r1_dout  = rd1[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [34:0] outs0();
    return {a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
            ram_en, ram_wen, ram_addr, ram_din, busy};
  endfunction

  initial begin
    #1;
    chk("reset_outs", outs0(), 35'd0);
    tick(); tick();
    rst = 1'b0;

    // single writer A: addr i <= 8'h10+i, one grant every 2 cycles
    for (int i = 0; i < 16; i++) begin
      a_req = 1; a_we = 1; a_addr = 4'(i); a_wdata = 8'(8'h10 + i);
      tick();
      chk($sformatf("wr%0d_cmd", i), {a_gnt, b_gnt, ram_en, ram_wen, ram_addr, ram_din},
          {1'b1, 1'b0, 1'b1, 1'b1, 4'(i), 8'(8'h10 + i)});
      if (i == 15) a_req = 0;
      tick();
      chk($sformatf("wr%0d_gap", i), {a_gnt, ram_en, busy}, 3'b000);
    end

    // single reader B: addr 5, wdata must not reach ram_din on a read
    b_req = 1; b_we = 0; b_addr = 4'd5; b_wdata = 8'hFF;
    tick();
    chk("rd5_cmd", {b_gnt, a_gnt, ram_en, ram_wen, ram_addr, ram_din},
        {1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 8'h00});
    b_req = 0;
    tick();
    chk("rd5_wait", {b_rvalid, busy}, 2'b01);
    tick();
    chk("rd5_resp", {b_rvalid, b_rdata, a_rvalid, a_rdata, busy},
        {1'b1, 8'h15, 1'b0, 8'h00, 1'b0});
    tick();
    chk("rd5_hold", {b_rvalid, b_rdata}, {1'b0, 8'h15});

    // last grant was B: A write wins the tie, B read then sees the new data
    a_req = 1; a_we = 1; a_addr = 4'd3; a_wdata = 8'hA5;
    b_req = 1; b_we = 0; b_addr = 4'd3; b_wdata = 8'h00;
    tick();
    chk("ord_a", {a_gnt, b_gnt, ram_wen, ram_addr, ram_din}, {2'b10, 1'b1, 4'd3, 8'hA5});
    a_req = 0;
    tick();
    tick();
    chk("ord_b", {a_gnt, b_gnt, ram_wen, ram_addr}, {2'b01, 1'b0, 4'd3});
    b_req = 0;
    tick();
    tick();
    chk("ord_resp", {b_rvalid, b_rdata, a_rvalid}, {1'b1, 8'hA5, 1'b0});

    // contention straight after reset: A, B, A, B ...
    rst = 1; tick(); rst = 0;
    a_req = 1; a_we = 1; a_addr = 4'd8; a_wdata = 8'h80;
    b_req = 1; b_we = 1; b_addr = 4'd9; b_wdata = 8'h90;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("rr%0d_gnt", k), {a_gnt, b_gnt, ram_addr},
          {k[0] ? 2'b01 : 2'b10, k[0] ? 4'd9 : 4'd8});
      if (k == 7) begin a_req = 0; b_req = 0; end
      tick();
      chk($sformatf("rr%0d_gap", k), {a_gnt, b_gnt}, 2'b00);
    end

    // A reads addr 8 so a_rdata is non-zero before the reset
    a_req = 1; a_we = 0; a_addr = 4'd8;
    tick(); a_req = 0;
    tick(); tick();
    chk("pre_rst_resp", {a_rvalid, a_rdata}, {1'b1, 8'h80});

    // reset during RD aborts the read
    a_req = 1; a_we = 0; a_addr = 4'd9;
    tick();
    chk("abort_gnt", a_gnt, 1'b1);
    a_req = 0;
    tick();
    chk("abort_in_rd", busy, 1'b1);
    rst = 1; #1;
    chk("abort_outs", outs0(), 35'd0);
    tick(); rst = 0;
    tick();
    chk("abort_no_rv1", {a_rvalid, b_rvalid, busy}, 3'b000);
    tick();
    chk("abort_no_rv2", {a_rvalid, b_rvalid, busy}, 3'b000);
    a_req = 1; a_we = 1; a_addr = 4'd1; a_wdata = 8'h11;
    tick();
    chk("post_rst_gnt", {a_gnt, b_gnt}, 2'b10);
    a_req = 0;
    tick();

    // RD_LAT=3 instance: write 7=3C, then read it back
    c_req = 1; c_we = 1; c_addr = 4'd7; c_wdata = 8'h3C;
    tick();
    chk("l3_wr", {c_gnt, r1_wen, r1_addr, r1_din}, {2'b11, 4'd7, 8'h3C});
    c_we = 0;
    tick();
    chk("l3_gap", {c_gnt, busy1}, 2'b00);
    tick();
    chk("l3_rd_cmd", {c_gnt, r1_wen, busy1}, 3'b101);
    c_req = 0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("l3_wait%0d", k), {c_rvalid, busy1}, 2'b01);
    end
    tick();
    chk("l3_resp", {c_rvalid, c_rdata, busy1}, {1'b1, 8'h3C, 1'b0});
    tick();
    chk("l3_after", {c_rvalid, c_rdata}, {1'b0, 8'h3C});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
